// File: rtl/fixp_pkg.sv
// rtl/fixp_pkg.sv - shared fixed-point arithmetic definitions (states, width helpers)
package fixp_pkg;

  // Sequencer states shared by the multiplier and the iterative divider
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    SIGN  = 2'd3
  } fixp_state_e;

  // Widest operand the SMALLEST helper can describe
  localparam int FIXP_MAX_WIDTH = 64;

  // Magnitude width: the sign bit is dropped
  function automatic int widthu(input int width);
    return width - 1;
  endfunction

  // Most negative value (1 followed by WIDTHU zeros); truncate to the operand width
  function automatic logic [FIXP_MAX_WIDTH-1:0] smallest(input int width);
    return FIXP_MAX_WIDTH'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/fixp_round.sv
// rtl/fixp_round.sv - combinational round-half-to-even incrementer on a truncated magnitude
module fixp_round #(
  parameter int W = 32
) (
  input  logic [W-1:0] q,
  input  logic         r,
  input  logic         s,
  output logic [W-1:0] q_out,
  output logic         carry
);

  logic inc;

  // Round up above half, or at exactly half when q is odd (ties go to even)
  assign inc = r & (q[0] | s);
  assign {carry, q_out} = {1'b0, q} + (W + 1)'(inc);

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequential signed fixed-point shift-add multiplier; MUL_GAUSS_ROUND_EN selects Gaussian rounding
module mul_seq
  import fixp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FBITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             ovf,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] val
);

  localparam int WU   = widthu(WIDTH);
  localparam int ACCW = 2 * WU;
  localparam int CNTW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SMALLEST = WIDTH'(smallest(WIDTH));

`ifdef MUL_GAUSS_ROUND_EN
  localparam logic GAUSS_EN = 1'b1;
`else
  localparam logic GAUSS_EN = 1'b0;
`endif

  fixp_state_e      state;
  logic [WU-1:0]    au;
  logic [WU-1:0]    bu;
  logic [WU-1:0]    q_mag;
  logic [ACCW-1:0]  acc;
  logic [CNTW-1:0]  i;
  logic             sig_diff;

  logic [WIDTH-1:0] a_neg;
  logic [WIDTH-1:0] b_neg;
  logic [ACCW-1:0]  q_trunc;
  logic [ACCW-1:0]  q_rnd;
  logic             rnd_bit;
  logic             sticky;
  logic             rnd_carry;
  logic             q_ovf;

  assign a_neg   = -a;
  assign b_neg   = -b;
  assign q_trunc = acc >> FBITS;

  generate
    if (FBITS > 0) begin : g_rbit
      assign rnd_bit = acc[FBITS-1];
    end else begin : g_no_rbit
      assign rnd_bit = 1'b0;
    end
    if (FBITS > 1) begin : g_sticky
      assign sticky = |acc[FBITS-2:0];
    end else begin : g_no_sticky
      assign sticky = 1'b0;
    end
  endgenerate

  // With rounding disabled the round bit is masked, so q is plain truncation
  fixp_round #(.W(ACCW)) u_round (
    .q     (q_trunc),
    .r     (rnd_bit & GAUSS_EN),
    .s     (sticky),
    .q_out (q_rnd),
    .carry (rnd_carry)
  );

  assign q_ovf = rnd_carry | (|q_rnd[ACCW-1:WU]);

  // Control FSM and datapath: accept, shift-add one multiplier bit per cycle, round, apply sign
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
      val      <= '0;
      au       <= '0;
      bu       <= '0;
      q_mag    <= '0;
      acc      <= '0;
      i        <= '0;
      sig_diff <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            valid <= 1'b0;
            val   <= '0;
            if (a == SMALLEST || b == SMALLEST) begin
              done <= 1'b1;
              ovf  <= 1'b1;
              busy <= 1'b0;
            end else begin
              au       <= a[WIDTH-1] ? a_neg[WU-1:0] : a[WU-1:0];
              bu       <= b[WIDTH-1] ? b_neg[WU-1:0] : b[WU-1:0];
              sig_diff <= a[WIDTH-1] ^ b[WIDTH-1];
              acc      <= '0;
              i        <= '0;
              ovf      <= 1'b0;
              busy     <= 1'b1;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          acc <= (acc << 1) + (bu[WU-1] ? ACCW'(au) : '0);
          bu  <= bu << 1;
          i   <= i + 1'b1;
          if (i == CNTW'(WU - 1)) state <= ROUND;
        end
        ROUND: begin
          if (q_ovf) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            ovf   <= 1'b1;
            valid <= 1'b0;
            val   <= '0;
            state <= IDLE;
          end else begin
            q_mag <= q_rnd[WU-1:0];
            state <= SIGN;
          end
        end
        SIGN: begin
          val   <= (sig_diff && q_mag != '0) ? {1'b1, -q_mag} : {1'b0, q_mag};
          busy  <= 1'b0;
          done  <= 1'b1;
          valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - self-checking bench for mul_seq (Q16.16): vector table, random model, corner sequences
module tb_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        valid;
  logic        ovf;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] val;

  int nvec = 0;
  int nerr = 0;

  mul_seq #(.WIDTH(32), .FBITS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .valid (valid),
    .ovf   (ovf),
    .a     (a),
    .b     (b),
    .val   (val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] val;
    bit          valid;
    bit          ovf;
    int          lat;
  } vec_t;

`ifdef MUL_GAUSS_ROUND_EN
  localparam logic [31:0] R_P3 = 32'h0000_0002;
  localparam logic [31:0] R_N3 = 32'hFFFF_FFFE;
`else
  localparam logic [31:0] R_P3 = 32'h0000_0001;
  localparam logic [31:0] R_N3 = 32'hFFFF_FFFF;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact signed product, then magnitude rounding on plain integers
  task automatic model(input logic [31:0] ma, input logic [31:0] mb,
                       output logic [31:0] ev, output bit evalid, output bit eovf, output int elat);
    longint          sa, sb, p;
    longint unsigned m, q, rem;
    bit              neg;
    if (ma == 32'h8000_0000 || mb == 32'h8000_0000) begin
      ev = 0; evalid = 0; eovf = 1; elat = 0;
      return;
    end
    sa  = longint'($signed(ma));
    sb  = longint'($signed(mb));
    p   = sa * sb;
    neg = (p < 0);
    m   = neg ? longint'(-p) : longint'(p);
    q   = m / 65536;
    rem = m % 65536;
`ifdef MUL_GAUSS_ROUND_EN
    if (rem > 32768 || (rem == 32768 && (q % 2) == 1)) q = q + 1;
`endif
    if (q > 64'h7FFF_FFFF) begin
      ev = 0; evalid = 0; eovf = 1; elat = 32;
    end else begin
      ev = neg ? 32'(-q) : 32'(q);
      evalid = 1; eovf = 0; elat = 33;
    end
  endtask

  // Launch one operation; optionally hammer start with junk operands for `noise` cycles after acceptance
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input int noise,
                       output int lat, output bit busy_bad);
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    busy_bad = 0;
    while (lat < 100) begin
      if (done) break;
      if (!busy) busy_bad = 1;
      start = (lat < noise);
      a = $urandom;
      b = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (done && busy) busy_bad = 1;
  endtask

  task automatic run_vec(input string tag, input logic [31:0] ta, input logic [31:0] tb_, input int noise,
                         input logic [31:0] ev, input bit evalid, input bit eovf, input int elat);
    int lat;
    bit busy_bad;
    do_op(ta, tb_, noise, lat, busy_bad);
    check({tag, ".val"}, 64'(val), 64'(ev));
    check({tag, ".valid"}, 64'(valid), 64'(evalid));
    check({tag, ".ovf"}, 64'(ovf), 64'(eovf));
    check({tag, ".latency"}, 64'(lat), 64'(elat));
    check({tag, ".busy"}, 64'(busy_bad), 64'(0));
  endtask

  initial begin
    vec_t        tbl[$];
    logic [31:0] ev, ra, rb;
    bit          evalid, eovf;
    int          elat;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.outputs", 64'({busy, done, valid, ovf, val}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    tbl.push_back('{32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1, 0, 33});
    tbl.push_back('{32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000, 1, 0, 33});
    tbl.push_back('{32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000, 1, 0, 33});
    tbl.push_back('{32'h0000_0001, 32'h0000_8000, 32'h0000_0000, 1, 0, 33});
    tbl.push_back('{32'h0000_0003, 32'h0000_8000, R_P3,          1, 0, 33});
    tbl.push_back('{32'hFFFF_FFFD, 32'h0000_8000, R_N3,          1, 0, 33});
    tbl.push_back('{32'h0000_0005, 32'h0000_8000, 32'h0000_0002, 1, 0, 33});
    tbl.push_back('{32'hFFFF_FFFF, 32'h0000_4000, 32'h0000_0000, 1, 0, 33});
    tbl.push_back('{32'hFFFF_0000, 32'hFFFF_0000, 32'h0001_0000, 1, 0, 33});
    tbl.push_back('{32'h7FFF_FFFF, 32'h0001_0000, 32'h7FFF_FFFF, 1, 0, 33});
    tbl.push_back('{32'h7FFF_FFFF, 32'h0001_0001, 32'h0000_0000, 0, 1, 32});
    tbl.push_back('{32'h0100_0000, 32'h0100_0000, 32'h0000_0000, 0, 1, 32});
    tbl.push_back('{32'h8000_0000, 32'h0001_0000, 32'h0000_0000, 0, 1, 0});
    tbl.push_back('{32'h0002_0000, 32'h8000_0000, 32'h0000_0000, 0, 1, 0});
    tbl.push_back('{32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1, 0, 33});

    // Back-to-back: each launch raises start while the previous done is still high
    foreach (tbl[k])
      run_vec($sformatf("tbl%0d", k), tbl[k].a, tbl[k].b, 0, tbl[k].val, tbl[k].valid, tbl[k].ovf, tbl[k].lat);

    // done is a single-cycle pulse and the result holds afterwards
    @(posedge clk); #1;
    check("done.pulse", 64'(done), 64'(0));
    check("hold.val", 64'({valid, val}), 64'({1'b1, 32'h0003_0000}));

    // start with junk operands during CALC is ignored
    run_vec("busy_start", 32'h0001_8000, 32'h0002_0000, 6, 32'h0003_0000, 1, 0, 33);

    // Asynchronous reset while a result is held
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst.held", 64'({busy, done, valid, ovf, val}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-CALC, then a clean operation
    @(negedge clk);
    a = 32'h0003_0000; b = 32'h0002_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("mid.busy", 64'(busy), 64'(1));
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst.outputs", 64'({busy, done, valid, ovf, val}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst.no_done", 64'({busy, done}), 64'(0));
    run_vec("after_rst", 32'hFFFE_8000, 32'hFFFE_0000, 0, 32'h0003_0000, 1, 0, 33);

    // Random operands across magnitudes against the arithmetic model
    for (int n = 0; n < 150; n++) begin
      ra = $urandom;
      rb = $urandom;
      ra = $signed(ra) >>> $urandom_range(0, 31);
      rb = $signed(rb) >>> $urandom_range(0, 31);
      if (n % 37 == 5) ra = 32'h8000_0000;
      model(ra, rb, ev, evalid, eovf, elat);
      run_vec($sformatf("rnd%0d", n), ra, rb, 0, ev, evalid, eovf, elat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Sequential signed fixed-point multiplier with Gaussian (round-half-to-even) rounding, the companion to the iterative divider in the fixed-point arithmetic library. It computes `val = a * b` in the same Q format and uses the same start/busy/done/valid/ovf handshake, so the two units are interchangeable behind one controller. It uses a shift-add datapath that retires one multiplier bit per clock, trading latency for area in the tiny-GPU datapath.

## Interface
- `WIDTH`, 32: total bits of operands and result (integer + fractional).
- `FBITS`, 16: fractional bits within `WIDTH`; legal range 0..`WIDTH`-2.
- `clk` in 1: clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin calculation; sampled only in IDLE.
- `busy` out 1: calculation in progress.
- `done` out 1: calculation finished; high for exactly one cycle.
- `valid` out 1: `val` holds a good result; held until the next accepted `start`.
- `ovf` out 1: overflow; held until the next accepted `start`.
- `a` in `WIDTH`: signed multiplicand, sampled with `start`.
- `b` in `WIDTH`: signed multiplier, sampled with `start`.
- `val` out `WIDTH`: signed product.

## Operation
- **Width rules:**
  - WIDTHU = `WIDTH`-1.
  - Magnitudes `au` and `bu` are WIDTHU bits.
  - Product accumulator is 2·WIDTHU bits.
  - SMALLEST = 1 followed by WIDTHU zeros.
- **States:** IDLE, CALC, ROUND, SIGN, held in a 2-bit register.
- **IDLE:**
  - On `start`, clear `valid` and `val`.
  - If `a`==SMALLEST or `b`==SMALLEST, stay in IDLE and pulse `done`, with `ovf`=1, `busy`=0.
  - Otherwise:
    - register `au`=|a|, `bu`=|b|, and `sig_diff`=a_sign^b_sign;
    - clear the accumulator, counter `i`, and `ovf`;
    - set `busy`=1 and go to CALC.
- **CALC:**
  - Each cycle, shift the accumulator one position and conditionally add `au` for the current bit of `bu`, MSB first.
  - After WIDTHU cycles (`i`==WIDTHU-1), go to ROUND.
- **ROUND:**
  - q = acc >> FBITS; round bit r = acc[FBITS-1]; sticky s = OR of acc[FBITS-2:0].
  - If r && (q[0] || s), then q = q+1.
  - If the rounded q does not fit in WIDTHU bits, go to IDLE with `busy`=0, `done`=1, `ovf`=1, `valid`=0, `val`=0.
  - Otherwise go to SIGN.
- **SIGN:**
  - If q≠0, `val` = `sig_diff` ? {1, −q} : {0, q}; a zero product gives `val`=0, never negative.
  - Set `busy`=0, `done`=1, `valid`=1, then go to IDLE.
- **FBITS=0:** no rounding; ROUND only checks overflow.
- **Boundaries:**
  - `start` while busy is ignored, and `a`/`b` may change freely after acceptance.
  - `start` in the same cycle that `done` is asserted (state is IDLE) is accepted.
  - Zero operand gives `val`=0, `valid`=1, normal latency.
- **Reset:**
  - `rst_n` low, at any time including mid-calculation, forces IDLE immediately.
  - All of `busy`, `done`, `valid`, `ovf`, `val` go to 0, and the operation in progress is discarded.

## Timing
- **Reset values:** `busy`=0, `done`=0, `valid`=0, `ovf`=0, `val`=0.
- **Normal result:** `done` is set on edge E0+WIDTHU+2, where E0 is the edge that samples `start` (33 edges for WIDTH=32).
- **Rounding overflow:** `done` is set on edge E0+WIDTHU+1.
- **SMALLEST operand:** `done` is set on E0 itself; `busy` never asserts.
- **`busy`:** high from E0 until the edge that sets `done`.
- **Output stability:** `val`, `valid`, and `ovf` change only at E0 and at the `done` edge.

## Configuration
- **Macro:** `MUL_GAUSS_ROUND_EN`.
- **Defined:** Gaussian rounding as above.
- **Undefined:**
  - Magnitude truncation (round toward zero); q = acc >> FBITS.
  - The ROUND state still exists for the overflow check, so latency is unchanged.
  - Expected results in rounding tests change accordingly.

## Structure
- **Shared package `fixp_pkg`:**
  - state encodings IDLE/CALC/ROUND/SIGN, reused by the divider;
  - the SMALLEST constant;
  - the WIDTHU derivation.
- **Sub-module `fixp_round`:**
  - combinational Gaussian rounder;
  - inputs: truncated q, r, s;
  - outputs: q', carry-out;
  - shareable with the divider.
- Everything else lives in `mul_seq`.

## Test plan
- Q16.16: `a`=0x00018000 (1.5), `b`=0x00020000 (2.0) -> `val`=0x00030000, `valid`=1, `ovf`=0, `done` 33 edges after `start`, `busy` high throughout.
- `a`=0xFFFE8000 (−1.5), `b`=0x00020000 -> `val`=0xFFFD0000; `a`=0x00000000, `b`=0xFFFF0000 -> `val`=0x00000000.
- Rounding: `a`=0x00000001, `b`=0x00008000 (exact half, even) -> `val`=0x00000000; `a`=0x00000003, `b`=0x00008000 -> `val`=0x00000002; without the macro -> 0x00000001.
- Overflow: `a`=`b`=0x01000000 (256.0) -> `ovf`=1, `valid`=0, `val`=0, `done` 32 edges after `start`. `a`=0x80000000 -> `done` and `ovf` on the sampling edge, `busy` stays 0.
- Assert `start` with new operands during CALC -> ignored, and the first result is unchanged. Pull `rst_n` low mid-CALC -> all outputs 0 asynchronously; the next `start` computes correctly.
